vga_sync_gen: RTL and testbench

//  VGA raster timing generator; consumes the half-period-shifted pixel clock and drives the BASYS2 VGA connector.

---
 rtl/vga_sync_gen.sv | 94 +++++++++
 tb/tb_vga_sync_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: hsync/vsync, visible-area flag and pixel coordinate.
// Define VGA_CLKDIV2_EN when clk runs at twice the pixel rate (raster advances every other clk).
module vga_sync_gen #(
   parameter int   H_VIS  = 640,
   parameter int   H_FP   = 16,
   parameter int   H_SYNC = 96,
   parameter int   H_BP   = 48,
   parameter int   V_VIS  = 480,
   parameter int   V_FP   = 10,
   parameter int   V_SYNC = 2,
   parameter int   V_BP   = 33,
   parameter logic HS_POL = 1'b0,
   parameter logic VS_POL = 1'b0,
   parameter int   CW     = 10
) (
   input  logic          clk,
   input  logic          rst,
   output logic          pix_tick,
   output logic          hsync,
   output logic          vsync,
   output logic          video_on,
   output logic [CW-1:0] px_x,
   output logic [CW-1:0] px_y,
   output logic          line_start,
   output logic          frame_start
);
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG = H_VIS + H_FP;
   localparam int HS_END = H_VIS + H_FP + H_SYNC;
   localparam int VS_BEG = V_VIS + V_FP;
   localparam int VS_END = V_VIS + V_FP + V_SYNC;

   logic [CW-1:0] h, v, h_nxt, v_nxt;
   logic [31:0]   h32, v32;
   logic          adv;
   logic          hs_act, vs_act, vis;

`ifdef VGA_CLKDIV2_EN
   logic tgl;
   always_ff @(posedge clk) begin
      if (rst) tgl <= 1'b0;
      else     tgl <= ~tgl;
   end
   assign adv = tgl;
`else
   assign adv = 1'b1;
`endif

   // Compare in 32 bits so window ends equal to the total never overflow CW.
   assign h32 = 32'(h);
   assign v32 = 32'(v);

   always_comb begin
      h_nxt = h + 1'b1;
      v_nxt = v;
      if (h32 == 32'(H_TOT - 1)) begin
         h_nxt = '0;
         v_nxt = (v32 == 32'(V_TOT - 1)) ? '0 : v + 1'b1;
      end
      hs_act = (h32 >= 32'(HS_BEG)) && (h32 < 32'(HS_END));
      vs_act = (v32 >= 32'(VS_BEG)) && (v32 < 32'(VS_END));
      vis    = (h32 < 32'(H_VIS)) && (v32 < 32'(V_VIS));
   end

   // Outputs are snapshots of the pre-advance (h,v), so all of them lag the counters by one advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         h           <= '0;
         v           <= '0;
         pix_tick    <= 1'b0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         video_on    <= 1'b0;
         px_x        <= '0;
         px_y        <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pix_tick <= adv;
         if (adv) begin
            h           <= h_nxt;
            v           <= v_nxt;
            hsync       <= hs_act ? HS_POL : ~HS_POL;
            vsync       <= vs_act ? VS_POL : ~VS_POL;
            video_on    <= vis;
            px_x        <= h;
            px_y        <= v;
            line_start  <= (h == '0);
            frame_start <= (h == '0) && (v == '0);
         end
      end
   end
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing over two lines, plus a tiny active-high raster for frame-level checks.
module tb_vga_sync_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       pix_tick, hsync, vsync, video_on, line_start, frame_start;
   logic [9:0] px_x, px_y;
   logic       s_pix_tick, s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
   logic [3:0] s_px_x, s_px_y;

   vga_sync_gen dut (
      .clk(clk), .rst(rst), .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync),
      .video_on(video_on), .px_x(px_x), .px_y(px_y),
      .line_start(line_start), .frame_start(frame_start)
   );

   // 14x8 raster: visible 8x4, hsync x=10..12, vsync y=5..6, active-high.
   vga_sync_gen #(
      .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)
   ) dut_s (
      .clk(clk), .rst(rst), .pix_tick(s_pix_tick), .hsync(s_hsync), .vsync(s_vsync),
      .video_on(s_video_on), .px_x(s_px_x), .px_y(s_px_y),
      .line_start(s_line_start), .frame_start(s_frame_start)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rst_vals();
      chk("rst_hs", hsync, 1);       chk("rst_vs", vsync, 1);
      chk("rst_vid", video_on, 0);   chk("rst_x", px_x, 0);
      chk("rst_y", px_y, 0);         chk("rst_ls", line_start, 0);
      chk("rst_fs", frame_start, 0); chk("rst_pt", pix_tick, 0);
      chk("s_rst_hs", s_hsync, 0);   chk("s_rst_vs", s_vsync, 0);
      chk("s_rst_x", s_px_x, 0);     chk("s_rst_fs", s_frame_start, 0);
   endtask

   initial begin
      int hs_lo, vid, ls_cnt, last_ls, hs_first, hs_last, ex, ey, waited;
      bit found;
      hs_lo = 0; vid = 0; ls_cnt = 0; last_ls = -1; hs_first = -1; hs_last = -1;

      rst = 1'b1;
      repeat (3) begin
         tick();
         chk_rst_vals();
      end

      rst = 1'b0;
      for (int k = 0; k < 1600; k++) begin
         tick();
         if (k == 0) begin
            chk("first_x", px_x, 0);   chk("first_y", px_y, 0);
            chk("first_vid", video_on, 1);
            chk("first_ls", line_start, 1); chk("first_fs", frame_start, 1);
         end
         chk("pix_tick", pix_tick, 1);
         if (!hsync) begin
            hs_lo++;
            if (hs_first < 0) hs_first = int'(px_x);
            hs_last = int'(px_x);
         end
         if (video_on) vid++;
         if (line_start) begin
            if (last_ls >= 0) chk("ls_period", k - last_ls, 800);
            last_ls = k;
            ls_cnt++;
         end
         if (k < 224) begin
            ex = k % 14;
            ey = (k / 14) % 8;
            chk("s_x", s_px_x, ex);
            chk("s_y", s_px_y, ey);
            chk("s_hs", s_hsync, (ex >= 10 && ex < 13) ? 1 : 0);
            chk("s_vs", s_vsync, (ey >= 5 && ey < 7) ? 1 : 0);
            chk("s_vid", s_video_on, (ex < 8 && ey < 4) ? 1 : 0);
            chk("s_ls", s_line_start, (ex == 0) ? 1 : 0);
            chk("s_fs", s_frame_start, (ex == 0 && ey == 0) ? 1 : 0);
         end
      end
      chk("hs_low_cnt", hs_lo, 192);
      chk("hs_first_x", hs_first, 656);
      chk("hs_last_x", hs_last, 751);
      chk("vid_cnt", vid, 1280);
      chk("ls_cnt", ls_cnt, 2);
      chk("end_x", px_x, 799);
      chk("end_y", px_y, 1);
      chk("end_vs", vsync, 1);

      // Reset in the middle of both sync pulses of the small raster.
      found = 1'b0;
      waited = 0;
      while (!found && waited < 300) begin
         if (s_px_x == 4'd11 && s_px_y == 4'd5) found = 1'b1;
         else begin
            tick();
            waited++;
         end
      end
      chk("mid_wait", found, 1);
      chk("mid_hs_act", s_hsync, 1);
      chk("mid_vs_act", s_vsync, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_rst_vals();
      chk("mid_rst_vid", s_video_on, 0);
      chk("mid_rst_ls", s_line_start, 0);
      tick();
      chk("mid_x0", s_px_x, 0);  chk("mid_y0", s_px_y, 0);
      chk("mid_fs", s_frame_start, 1); chk("mid_vid", s_video_on, 1);
      chk("mid_pt", s_pix_tick, 1);
      chk("mid_dx0", px_x, 0);   chk("mid_dfs", frame_start, 1);
      tick();
      chk("mid_x1", s_px_x, 1);  chk("mid_fs1", s_frame_start, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
